// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers for the round engine.
package aes_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [3:0] column_t;

  localparam byte_t AES_POLY = 8'h1b;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_gf.sv
// Combinational MixColumns / InvMixColumns of one 4-byte column (index 0 is row 0).
module mix_column_gf
  import aes_pkg::*;
(
  input  column_t col_in,
  input  logic    inverse,
  output column_t col_out
);

  column_t x2, x4, x8;
  column_t m1, m2, m3, m4;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      x2[r] = xtime(col_in[r]);
      x4[r] = xtime(x2[r]);
      x8[r] = xtime(x4[r]);
    end
  end

  // Per-byte products for the four circulant coefficients of the selected matrix:
  // forward (02 03 01 01), inverse (0e 0b 0d 09).
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      if (inverse) begin
        m1[r] = x8[r] ^ x4[r] ^ x2[r];
        m2[r] = x8[r] ^ x2[r] ^ col_in[r];
        m3[r] = x8[r] ^ x4[r] ^ col_in[r];
        m4[r] = x8[r] ^ col_in[r];
      end else begin
        m1[r] = x2[r];
        m2[r] = x2[r] ^ col_in[r];
        m3[r] = col_in[r];
        m4[r] = col_in[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      col_out[r] = m1[r] ^ m2[2'(r + 1)] ^ m3[2'(r + 2)] ^ m4[2'(r + 3)];
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Multi-cycle AES MixColumns/InvMixColumns engine: COLS_PER_CYCLE columns per clock
// between a valid/ready input handshake and a valid/ready output handshake.
module mix_columns_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_inverse,
  output logic         busy
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state_q, state_d;
  logic [1:0]   col_q;
  logic [127:0] data_q, data_run;
  logic         inv_q;
  logic         accept;

  logic [1:0] idx     [COLS_PER_CYCLE];
  column_t    mix_in  [COLS_PER_CYCLE];
  column_t    mix_out [COLS_PER_CYCLE];

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
    assign idx[g]    = col_q + 2'(g);
    assign mix_in[g] = data_q[{idx[g], 5'b0} +: 32];

    mix_column_gf u_mix (
      .col_in  (mix_in[g]),
      .inverse (inv_q),
      .col_out (mix_out[g])
    );
  end

  // Columns outside the current group pass through untouched.
  always_comb begin
    data_run = data_q;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      data_run[{idx[g], 5'b0} +: 32] = mix_out[g];
    end
  end

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (col_q == LAST_COL) state_d = DONE;
      DONE: if (out_ready) state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      data_q  <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= in_data;
        inv_q  <= in_inverse;
        col_q  <= 2'd0;
      end else if (state_q == RUN) begin
        data_q <= data_run;
        col_q  <= col_q + COL_STEP;
      end
    end
  end

  assign out_valid   = (state_q == DONE);
  assign out_data    = data_q;
  assign out_inverse = inv_q;
  assign busy        = (state_q == RUN);

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (N = 1, 2, 4) checked against a GF(2^8) matrix model.
module tb_mix_columns_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid      [3];
  logic         in_inverse    [3];
  logic         out_ready     [3];
  logic [127:0] in_data       [3];
  logic         in_ready_w    [3];
  logic         out_valid_w   [3];
  logic         out_inverse_w [3];
  logic         busy_w        [3];
  logic [127:0] out_data_w    [3];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid[g]),
      .in_ready    (in_ready_w[g]),
      .in_data     (in_data[g]),
      .in_inverse  (in_inverse[g]),
      .out_valid   (out_valid_w[g]),
      .out_ready   (out_ready[g]),
      .out_data    (out_data_w[g]),
      .out_inverse (out_inverse_w[g]),
      .busy        (busy_w[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: generic shift-and-add GF(2^8) multiply and a coefficient table.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s, input logic inv);
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(coef[(j - row + 4) % 4], s[8*(4*c+j) +: 8]);
        r[8*(4*c+row) +: 8] = acc;
      end
    end
    return r;
  endfunction

  // Column written as printed bytes "row0 row1 row2 row3".
  function automatic logic [31:0] col(input logic [31:0] be);
    return {be[7:0], be[15:8], be[23:16], be[31:24]};
  endfunction

  function automatic logic [127:0] cols(input logic [31:0] c0, input logic [31:0] c1,
                                        input logic [31:0] c2, input logic [31:0] c3);
    return {col(c3), col(c2), col(c1), col(c0)};
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_txn(input int k, input logic [127:0] d, input logic inv,
                         output logic [127:0] res, output logic res_inv, output int lat);
    in_data[k]    = d;
    in_inverse[k] = inv;
    in_valid[k]   = 1'b1;
    out_ready[k]  = 1'b0;
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
    lat = 0;
    while (!out_valid_w[k] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("txn_out_valid_n%0d", 1 << k), out_valid_w[k], 1'b1);
    res     = out_data_w[k];
    res_inv = out_inverse_w[k];
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
  endtask

  typedef struct {
    logic [127:0] data;
    logic         inv;
  } exp_t;

  initial begin
    logic [127:0] res, res2, st, exp_st, fips_in, fips_out;
    logic         rinv, rinv2;
    int           lat, n_acc, n_out, extra;
    logic         acc, oh, mode;
    exp_t         q[$];
    exp_t         e;

    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_inverse[k] = 1'b0; out_ready[k] = 1'b0; in_data[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_out_valid_n%0d", 1 << k), out_valid_w[k], 1'b0);
      check($sformatf("rst_out_data_n%0d", 1 << k), out_data_w[k], '0);
      check($sformatf("rst_out_inverse_n%0d", 1 << k), out_inverse_w[k], 1'b0);
      check($sformatf("rst_busy_n%0d", 1 << k), busy_w[k], 1'b0);
      check($sformatf("rst_in_ready_n%0d", 1 << k), in_ready_w[k], 1'b1);
    end

    // Single forward column with latency.
    for (int k = 0; k < 3; k++) begin
      run_txn(k, cols(32'hdb135345, 0, 0, 0), 1'b0, res, rinv, lat);
      check($sformatf("fwd_latency_n%0d", 1 << k), lat, 4 >> k);
      check($sformatf("fwd_col0_n%0d", 1 << k), res, cols(32'h8e4da1bc, 0, 0, 0));
    end

    // FIPS-197 forward columns, then inverse back.
    fips_in  = cols(32'hf20a225c, 32'hd4d4d4d5, 32'hc6c6c6c6, 32'hdb135345);
    fips_out = cols(32'h9fdc589d, 32'hd5d5d7d6, 32'hc6c6c6c6, 32'h8e4da1bc);
    for (int k = 0; k < 3; k++) begin
      run_txn(k, fips_in, 1'b0, res, rinv, lat);
      check($sformatf("fips_fwd_n%0d", 1 << k), res, fips_out);
      check($sformatf("fips_fwd_mode_n%0d", 1 << k), rinv, 1'b0);
      run_txn(k, fips_out, 1'b1, res, rinv, lat);
      check($sformatf("fips_inv_n%0d", 1 << k), res, fips_in);
      check($sformatf("fips_inv_mode_n%0d", 1 << k), rinv, 1'b1);
    end

    // Random round trips.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 128; i++) begin
        st = rand_state();
        run_txn(k, st, 1'b0, res, rinv, lat);
        check($sformatf("rt_fwd_n%0d_%0d", 1 << k, i), res, mix_model(st, 1'b0));
        run_txn(k, res, 1'b1, res2, rinv2, lat);
        check($sformatf("rt_back_n%0d_%0d", 1 << k, i), res2, st);
      end
    end

    // Backpressure in DONE.
    st = rand_state();
    exp_st = mix_model(st, 1'b1);
    in_data[0] = st; in_inverse[0] = 1'b1; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid_w[0] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      in_valid[0] = i[0];
      in_data[0]  = rand_state();
      in_inverse[0] = 1'b0;
      check($sformatf("bp_out_valid_%0d", i), out_valid_w[0], 1'b1);
      check($sformatf("bp_out_data_%0d", i), out_data_w[0], exp_st);
      check($sformatf("bp_out_inverse_%0d", i), out_inverse_w[0], 1'b1);
      check($sformatf("bp_in_ready_%0d", i), in_ready_w[0], 1'b0);
      @(posedge clk); #1;
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    extra = 0;
    check("bp_release_valid", out_valid_w[0], 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      if (out_valid_w[0]) extra++;
      @(posedge clk); #1;
    end
    check("bp_single_handshake", extra, 0);
    check("bp_idle_busy", busy_w[0], 1'b0);
    out_ready[0] = 1'b0;

    // Back-to-back with alternating modes.
    n_acc = 0; n_out = 0; mode = 1'b0;
    in_data[0] = rand_state(); in_inverse[0] = mode;
    in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    for (int cyc = 0; cyc < 400 && n_out < 20; cyc++) begin
      @(negedge clk);
      acc = in_valid[0] && in_ready_w[0];
      oh  = out_valid_w[0] && out_ready[0];
      if (out_valid_w[0] && n_acc < 20)
        check($sformatf("b2b_accept_in_done_%0d", n_out), in_ready_w[0] && in_valid[0], 1'b1);
      if (oh) begin
        if (q.size() == 0) begin
          check("b2b_extra_out", out_valid_w[0], 1'b0);
        end else begin
          e = q.pop_front();
          check($sformatf("b2b_data_%0d", n_out), out_data_w[0], e.data);
          check($sformatf("b2b_mode_%0d", n_out), out_inverse_w[0], e.inv);
        end
        n_out++;
      end
      if (acc) begin
        q.push_back('{mix_model(in_data[0], in_inverse[0]), in_inverse[0]});
        n_acc++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (n_acc == 20) begin
          in_valid[0] = 1'b0;
        end else begin
          mode = ~mode;
          in_data[0] = rand_state();
          in_inverse[0] = mode;
        end
      end
    end
    check("b2b_out_count", n_out, 20);
    check("b2b_queue_empty", q.size(), 0);
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in RUN at col = 1.
    in_data[0] = rand_state(); in_inverse[0] = 1'b1; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    check("mid_busy_before_reset", busy_w[0], 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid_w[0], 1'b0);
    check("arst_out_data", out_data_w[0], '0);
    check("arst_out_inverse", out_inverse_w[0], 1'b0);
    check("arst_busy", busy_w[0], 1'b0);
    check("arst_in_ready", in_ready_w[0], 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    st = rand_state();
    run_txn(0, st, 1'b0, res, rinv, lat);
    check("post_reset_latency", lat, 4);
    check("post_reset_data", res, mix_model(st, 1'b0));
    check("post_reset_mode", rinv, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
